adf4351_spi_writer: RTL and testbench
=====================================

# adf4351_spi_writer

Serial register writer for the ADF4351 synthesizer, directly downstream of the frequency calculator that produces the R0/R4 words. Latches the R0/R4 words on a start strobe and shifts them MSB-first over the ADF4351 3-wire interface (SCLK/SDATA/LE), one LE pulse per 32-bit word. A separate init request writes the full R5..R0 sequence, with R1/R2/R3/R5 taken from parameters. Its DONE pulse reports that the synthesizer has been programmed.

## Interface
- HALF_PERIOD, 4: SCLK half period in CLK cycles; legal range ≥1.
- LE_CYCLES, 4: LE high width in CLK cycles; legal range ≥1.
- R1_VAL, 32'h08008011: static R1 word.
- R2_VAL, 32'h00004E42: static R2 word.
- R3_VAL, 32'h000004B3: static R3 word.
- R5_VAL, 32'h00580005: static R5 word.

- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- START  in  1  update request; writes R4 then R0. Normally driven by the calculator's DONE.
- INIT  in  1  full init request; writes R5, R4, R3, R2, R1, R0.
- R0  in  32  R0 word, sampled on accept.
- R4  in  32  R4 word, sampled on accept.
- BUSY  out  1  transfer in progress.
- DONE  out  1  one-cycle pulse when the last word's sequence completes.
- SCLK  out  1  serial clock to ADF4351.
- SDATA  out  1  serial data, MSB first.
- LE  out  1  load enable; pulses high after each 32-bit word.

## Operation
- Reset (any time, including mid-word) forces SCLK=0, SDATA=0, LE=0, BUSY=0, DONE=0, and the FSM to IDLE.
  - Any partial word is abandoned without an LE pulse, so the device ignores it.
- FSM states: IDLE, SHIFT_LO, SHIFT_HI, LE_SETUP, LE_HIGH, GAP.
- IDLE:
  - A request is accepted on a rising edge where BUSY=0 and START or INIT is high.
  - INIT has priority if both are high.
  - On accept: R0/R4 are latched, the word list is selected (2 words for update, 6 for init), and the FSM moves to SHIFT_LO with bit index 31.
- START/INIT while BUSY=1 are ignored; they are not queued. Input changes after accept do not affect the words in flight.
- SHIFT_LO: SCLK=0, SDATA=word[bit], held HALF_PERIOD cycles, then → SHIFT_HI.
- SHIFT_HI: SCLK=1, held HALF_PERIOD cycles. The device samples on the SCLK rise.
  - If bit>0: decrement bit, → SHIFT_LO.
  - Else → LE_SETUP.
- LE_SETUP: SCLK=0, SDATA=0, held HALF_PERIOD cycles, → LE_HIGH.
- LE_HIGH: LE=1, held LE_CYCLES cycles, → GAP.
- GAP: LE=0, held HALF_PERIOD cycles.
  - If more words remain: load the next word, bit=31, → SHIFT_LO.
  - Else: DONE=1 for one cycle, BUSY=0, → IDLE.
- Word order:
  - Update: R4, R0.
  - Init: R5_VAL, R4, R3_VAL, R2_VAL, R1_VAL, R0.
  - R0 is always written last, since the R0 write triggers the device's double-buffered update.
- Counters:
  - Phase counter is wide enough for max(HALF_PERIOD, LE_CYCLES)−1.
  - Bit counter is 5 bits.
  - Word index is 3 bits.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Timing
- Accept edge = cycle 0.
- BUSY=1 and the first SHIFT_LO cycle begin at cycle 1; SDATA=bit31 is valid from cycle 1.
- Per-word length W = 64·HALF_PERIOD + 2·HALF_PERIOD + LE_CYCLES.
  - Defaults: W = 256 + 8 + 4 = 268 cycles.
- Update: DONE high at cycle 2W+1 (537 at defaults), and BUSY=0 in that same cycle.
- Init: DONE high at cycle 6W+1 (1609 at defaults).
- SDATA changes only while SCLK=0.
  - Setup to the SCLK rise = HALF_PERIOD cycles.
  - Hold after the SCLK fall ≥ 0 cycles; SDATA changes on the edge where SCLK falls.
- LE rises HALF_PERIOD cycles after the last SCLK fall and never overlaps SCLK=1.
- A new request can be accepted on the edge after the DONE cycle, so back-to-back transfers are legal.

## Test plan
- Reset: assert RST mid-simulation.
  - Required: all outputs 0 asynchronously.
  - After release, no SCLK edges until a request arrives.
- Update with defaults: R4=32'h00AC803C, R0=32'h00501F40, START pulse.
  - A bench shift-register model clocked on SCLK rise and latched on LE rise captures 00AC803C then 00501F40.
  - Exactly 2 LE pulses; DONE at cycle 537; 64 SCLK rises total.
- Init: INIT pulse.
  - Captured words in order: 00580005, R4, 000004B3, 00004E42, 08008011, R0.
  - DONE at cycle 1609.
- Busy rejection:
  - Pulse START again at cycle 100 with different R0/R4. Required: ignored; captured words unchanged; no second DONE.
  - START and INIT high in the same cycle. Required: init sequence (6 LE pulses).
- Reset mid-word: assert RST at cycle 50 of an update.
  - Required: no LE pulse ever occurs.
  - A subsequent START yields a clean, correct 2-word transfer.
- HALF_PERIOD=1, LE_CYCLES=1:
  - W = 67, DONE at cycle 135.
  - SCLK toggles every cycle; captured data correct; back-to-back START on the edge after DONE is accepted.

Source files
------------

// File: rtl/adf4351_spi_writer.sv
// ADF4351 3-wire register writer: shifts R4,R0 (update) or R5..R0 (init)
// MSB-first on SCLK/SDATA with one LE pulse per 32-bit word.
module adf4351_spi_writer #(
  parameter int unsigned HALF_PERIOD = 4,
  parameter int unsigned LE_CYCLES   = 4,
  parameter logic [31:0] R1_VAL      = 32'h08008011,
  parameter logic [31:0] R2_VAL      = 32'h00004E42,
  parameter logic [31:0] R3_VAL      = 32'h000004B3,
  parameter logic [31:0] R5_VAL      = 32'h00580005
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        init_i,
  input  logic [31:0] r0_i,
  input  logic [31:0] r4_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        sclk_o,
  output logic        sdata_o,
  output logic        le_o
);

  localparam int unsigned PH_MAX = (HALF_PERIOD > LE_CYCLES) ? HALF_PERIOD : LE_CYCLES;
  localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam logic [PH_W-1:0] HP_LAST = PH_W'(HALF_PERIOD - 1);
  localparam logic [PH_W-1:0] LE_LAST = PH_W'(LE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHIFT_LO = 3'd1,
    SHIFT_HI = 3'd2,
    LE_SETUP = 3'd3,
    LE_HIGH  = 3'd4,
    GAP      = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [PH_W-1:0] phase_q, phase_d;
  logic [4:0]      bit_q,   bit_d;
  logic [2:0]      widx_q,  widx_d;
  logic [31:0]     sreg_q,  sreg_d;
  logic [31:0]     r0_q,    r0_d;
  logic [31:0]     r4_q,    r4_d;
  logic            init_q,  init_d;
  logic            busy_q,  busy_d;
  logic            done_q,  done_d;
  logic            sclk_q,  sclk_d;
  logic            sdata_q, sdata_d;
  logic            le_q,    le_d;
  logic            hp_end,  le_end;
  logic [2:0]      last_idx;

  // Word list: R0 always last so the device's double-buffered update fires at the end.
  function automatic logic [31:0] pick_word(input logic        is_init,
                                            input logic [2:0]  idx,
                                            input logic [31:0] r0,
                                            input logic [31:0] r4);
    logic [31:0] w;
    if (is_init) begin
      case (idx)
        3'd0:    w = R5_VAL;
        3'd1:    w = r4;
        3'd2:    w = R3_VAL;
        3'd3:    w = R2_VAL;
        3'd4:    w = R1_VAL;
        default: w = r0;
      endcase
    end else begin
      w = (idx == 3'd0) ? r4 : r0;
    end
    return w;
  endfunction

  // State and output registers; reset abandons any partial word without LE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      phase_q <= '0;
      bit_q   <= '0;
      widx_q  <= '0;
      sreg_q  <= '0;
      r0_q    <= '0;
      r4_q    <= '0;
      init_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sclk_q  <= 1'b0;
      sdata_q <= 1'b0;
      le_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      widx_q  <= widx_d;
      sreg_q  <= sreg_d;
      r0_q    <= r0_d;
      r4_q    <= r4_d;
      init_q  <= init_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sclk_q  <= sclk_d;
      sdata_q <= sdata_d;
      le_q    <= le_d;
    end
  end

  // Next-state logic; outputs are derived from the next state so they land registered.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    bit_d    = bit_q;
    widx_d   = widx_q;
    sreg_d   = sreg_q;
    r0_d     = r0_q;
    r4_d     = r4_q;
    init_d   = init_q;
    done_d   = 1'b0;
    hp_end   = (phase_q == HP_LAST);
    le_end   = (phase_q == LE_LAST);
    last_idx = init_q ? 3'd5 : 3'd1;

    case (state_q)
      IDLE: begin
        if (init_i || start_i) begin
          init_d  = init_i;
          r0_d    = r0_i;
          r4_d    = r4_i;
          widx_d  = 3'd0;
          bit_d   = 5'd31;
          phase_d = '0;
          sreg_d  = pick_word(init_i, 3'd0, r0_i, r4_i);
          state_d = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (hp_end) begin
          phase_d = '0;
          state_d = SHIFT_HI;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      SHIFT_HI: begin
        if (hp_end) begin
          phase_d = '0;
          if (bit_q != 5'd0) begin
            bit_d   = bit_q - 5'd1;
            sreg_d  = {sreg_q[30:0], 1'b0};
            state_d = SHIFT_LO;
          end else begin
            state_d = LE_SETUP;
          end
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      LE_SETUP: begin
        if (hp_end) begin
          phase_d = '0;
          state_d = LE_HIGH;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      LE_HIGH: begin
        if (le_end) begin
          phase_d = '0;
          state_d = GAP;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      GAP: begin
        if (hp_end) begin
          phase_d = '0;
          if (widx_q != last_idx) begin
            widx_d  = widx_q + 3'd1;
            sreg_d  = pick_word(init_q, widx_q + 3'd1, r0_q, r4_q);
            bit_d   = 5'd31;
            state_d = SHIFT_LO;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      default: begin
        phase_d = '0;
        state_d = IDLE;
      end
    endcase

    busy_d  = (state_d != IDLE);
    sclk_d  = (state_d == SHIFT_HI);
    sdata_d = ((state_d == SHIFT_LO) || (state_d == SHIFT_HI)) ? sreg_d[31] : 1'b0;
    le_d    = (state_d == LE_HIGH);
  end

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign sclk_o  = sclk_q;
  assign sdata_o = sdata_q;
  assign le_o    = le_q;

endmodule

// File: tb/tb_adf4351_spi_writer.sv
// Scoreboard bench: a default-timing instance (a_*) and a fast HALF_PERIOD=1/LE_CYCLES=1
// instance (f_*); a shift-register model on SCLK/LE captures words for comparison.
module tb_adf4351_spi_writer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  logic        a_start = 1'b0, a_init = 1'b0;
  logic [31:0] a_r0 = '0, a_r4 = '0;
  logic        a_busy, a_done, a_sclk, a_sdata, a_le;
  logic        f_start = 1'b0, f_init = 1'b0;
  logic [31:0] f_r0 = '0, f_r4 = '0;
  logic        f_busy, f_done, f_sclk, f_sdata, f_le;

  adf4351_spi_writer u_dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(a_start), .init_i(a_init),
    .r0_i(a_r0), .r4_i(a_r4), .busy_o(a_busy), .done_o(a_done),
    .sclk_o(a_sclk), .sdata_o(a_sdata), .le_o(a_le));

  adf4351_spi_writer #(.HALF_PERIOD(1), .LE_CYCLES(1)) u_dut_f (
    .clk_i(clk), .rst_i(rst), .start_i(f_start), .init_i(f_init),
    .r0_i(f_r0), .r4_i(f_r4), .busy_o(f_busy), .done_o(f_done),
    .sclk_o(f_sclk), .sdata_o(f_sdata), .le_o(f_le));

  always #5 clk = ~clk;

  // Free-running cycle number, used to time DONE against the accept cycle.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard / monitor, default instance ----------------
  logic [31:0] a_expw[$];
  int          a_expdone[$];
  logic [31:0] a_sh;
  int          a_sclk_cnt = 0, a_le_cnt = 0, a_viol = 0, a_acc0 = 0;
  logic        a_sdata_p = 1'b0;

  // Device model: shift on SCLK rise.
  always @(posedge a_sclk) begin
    a_sh       <= {a_sh[30:0], a_sdata};
    a_sclk_cnt <= a_sclk_cnt + 1;
  end

  // Device model: latch on LE rise and compare to the next expected word.
  always @(posedge a_le) begin
    a_le_cnt <= a_le_cnt + 1;
    if (a_expw.size() == 0) check("a_unexpected_le", 64'(a_sh), 64'hFFFF_FFFF_FFFF_FFFF);
    else                    check("a_word", 64'(a_sh), 64'(a_expw.pop_front()));
  end

  // DONE timing and serial protocol rules, sampled mid-cycle.
  always @(negedge clk) begin
    if (a_done === 1'b1) begin
      if (a_expdone.size() == 0) check("a_unexpected_done", 64'(cyc), 64'hFFFF_FFFF_FFFF_FFFF);
      else                       check("a_done_cycle", 64'(cyc), 64'(a_expdone.pop_front()));
    end
    if (a_sclk === 1'b1 && a_sdata !== a_sdata_p) a_viol <= a_viol + 1;
    if (a_sclk === 1'b1 && a_le === 1'b1)         a_viol <= a_viol + 1;
    a_sdata_p <= a_sdata;
  end

  // ---------------- scoreboard / monitor, fast instance ----------------
  logic [31:0] f_expw[$];
  int          f_expdone[$];
  logic [31:0] f_sh;
  int          f_sclk_cnt = 0, f_le_cnt = 0, f_viol = 0, f_acc0 = 0;
  logic        f_sdata_p = 1'b0;

  // Device model: shift on SCLK rise.
  always @(posedge f_sclk) begin
    f_sh       <= {f_sh[30:0], f_sdata};
    f_sclk_cnt <= f_sclk_cnt + 1;
  end

  // Device model: latch on LE rise and compare.
  always @(posedge f_le) begin
    f_le_cnt <= f_le_cnt + 1;
    if (f_expw.size() == 0) check("f_unexpected_le", 64'(f_sh), 64'hFFFF_FFFF_FFFF_FFFF);
    else                    check("f_word", 64'(f_sh), 64'(f_expw.pop_front()));
  end

  // DONE timing and serial protocol rules for the fast instance.
  always @(negedge clk) begin
    if (f_done === 1'b1) begin
      if (f_expdone.size() == 0) check("f_unexpected_done", 64'(cyc), 64'hFFFF_FFFF_FFFF_FFFF);
      else                       check("f_done_cycle", 64'(cyc), 64'(f_expdone.pop_front()));
    end
    if (f_sclk === 1'b1 && f_sdata !== f_sdata_p) f_viol <= f_viol + 1;
    if (f_sclk === 1'b1 && f_le === 1'b1)         f_viol <= f_viol + 1;
    f_sdata_p <= f_sdata;
  end

  // ---------------- stimulus ----------------
  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // One-cycle request; a_acc0 is the cycle in which the request is sampled (cycle 0).
  task automatic a_req(input logic s, input logic i, input logic [31:0] r4, input logic [31:0] r0);
    @(negedge clk);
    a_start = s; a_init = i; a_r4 = r4; a_r0 = r0; a_acc0 = cyc;
    @(negedge clk);
    a_start = 1'b0; a_init = 1'b0;
  endtask

  task automatic f_req(input logic s, input logic i, input logic [31:0] r4, input logic [31:0] r0);
    @(negedge clk);
    f_start = s; f_init = i; f_r4 = r4; f_r0 = r0; f_acc0 = cyc;
    @(negedge clk);
    f_start = 1'b0; f_init = 1'b0;
  endtask

  task automatic push_init_a(input logic [31:0] r4, input logic [31:0] r0);
    a_expw.push_back(32'h00580005);
    a_expw.push_back(r4);
    a_expw.push_back(32'h000004B3);
    a_expw.push_back(32'h00004E42);
    a_expw.push_back(32'h08008011);
    a_expw.push_back(r0);
    a_expdone.push_back(a_acc0 + 1609);
  endtask

  int le0, sc0, acc_b;

  initial begin
    // Reset state and quiet bus after release.
    repeat (3) @(negedge clk);
    check("a_reset_outputs", 64'({a_busy, a_done, a_sclk, a_sdata, a_le}), 64'd0);
    check("f_reset_outputs", 64'({f_busy, f_done, f_sclk, f_sdata, f_le}), 64'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("a_idle_no_sclk", 64'(a_sclk_cnt + a_le_cnt), 64'd0);
    check("f_idle_no_sclk", 64'(f_sclk_cnt + f_le_cnt), 64'd0);

    // Update R4 then R0, with a START at cycle 100 that must be ignored.
    le0 = a_le_cnt; sc0 = a_sclk_cnt;
    a_req(1'b1, 1'b0, 32'h00AC803C, 32'h00501F40);
    a_expw.push_back(32'h00AC803C);
    a_expw.push_back(32'h00501F40);
    a_expdone.push_back(a_acc0 + 537);
    check("a_cycle1_busy_sclk_sdata_le", 64'({a_busy, a_sclk, a_sdata, a_le}), 64'b1000);
    wait_cyc(a_acc0 + 100);
    a_start = 1'b1; a_r4 = 32'h11111111; a_r0 = 32'h22222222;
    @(negedge clk);
    a_start = 1'b0;
    wait_cyc(a_acc0 + 545);
    check("a_update_le_pulses", 64'(a_le_cnt - le0), 64'd2);
    check("a_update_sclk_rises", 64'(a_sclk_cnt - sc0), 64'd64);
    check("a_update_idle_after", 64'(a_busy), 64'd0);

    // Full init.
    le0 = a_le_cnt;
    a_req(1'b0, 1'b1, 32'h00EC803C, 32'h00A08000);
    push_init_a(32'h00EC803C, 32'h00A08000);
    wait_cyc(a_acc0 + 1615);
    check("a_init_le_pulses", 64'(a_le_cnt - le0), 64'd6);

    // START and INIT together: INIT wins.
    le0 = a_le_cnt;
    a_req(1'b1, 1'b1, 32'h0099A03C, 32'h00C81F40);
    push_init_a(32'h0099A03C, 32'h00C81F40);
    wait_cyc(a_acc0 + 1615);
    check("a_both_le_pulses", 64'(a_le_cnt - le0), 64'd6);

    // Reset in the middle of the first word: nothing may be latched.
    le0 = a_le_cnt;
    a_req(1'b1, 1'b0, 32'h00AC803C, 32'h00501F40);
    wait_cyc(a_acc0 + 50);
    #2 rst = 1'b1;
    #1 check("a_async_reset_outputs", 64'({a_busy, a_done, a_sclk, a_sdata, a_le}), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sc0 = a_sclk_cnt;
    repeat (20) @(negedge clk);
    check("a_after_reset_no_sclk", 64'(a_sclk_cnt - sc0), 64'd0);
    check("a_after_reset_no_le", 64'(a_le_cnt - le0), 64'd0);
    a_req(1'b1, 1'b0, 32'h00AC803C, 32'h00501F40);
    a_expw.push_back(32'h00AC803C);
    a_expw.push_back(32'h00501F40);
    a_expdone.push_back(a_acc0 + 537);
    wait_cyc(a_acc0 + 545);
    check("a_recover_le_pulses", 64'(a_le_cnt - le0), 64'd2);

    // Fast timing: W=67, DONE at 135, then back-to-back START in the DONE cycle.
    le0 = f_le_cnt; sc0 = f_sclk_cnt;
    f_req(1'b1, 1'b0, 32'h00AC803C, 32'h00501F40);
    f_expw.push_back(32'h00AC803C);
    f_expw.push_back(32'h00501F40);
    f_expdone.push_back(f_acc0 + 135);
    wait_cyc(f_acc0 + 135);
    check("f_done_busy_in_done_cycle", 64'({f_done, f_busy}), 64'b10);
    f_start = 1'b1; f_r4 = 32'h00CC803C; f_r0 = 32'h00321F40; acc_b = cyc;
    f_expw.push_back(32'h00CC803C);
    f_expw.push_back(32'h00321F40);
    f_expdone.push_back(acc_b + 135);
    @(negedge clk);
    f_start = 1'b0;
    check("f_b2b_accepted", 64'(f_busy), 64'd1);
    wait_cyc(acc_b + 140);
    check("f_le_pulses", 64'(f_le_cnt - le0), 64'd4);
    check("f_sclk_rises", 64'(f_sclk_cnt - sc0), 64'd128);

    // Nothing left outstanding and no protocol violations.
    check("a_words_left", 64'(a_expw.size()), 64'd0);
    check("a_dones_left", 64'(a_expdone.size()), 64'd0);
    check("f_words_left", 64'(f_expw.size()), 64'd0);
    check("f_dones_left", 64'(f_expdone.size()), 64'd0);
    check("a_protocol_violations", 64'(a_viol), 64'd0);
    check("f_protocol_violations", 64'(f_viol), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
